// File: rtl/rf_pkt_pkg.sv
// Shared types and defaults for the RF packet capture path.
package rf_pkt_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    HOLD = 1'b1
  } cap_state_t;

  localparam int          PKT_W_DEF      = 64;
  localparam logic [63:0] SYNC_MASK_DEF  = 64'h7C00_001F_0000_0000;
  localparam logic [63:0] SYNC_PAT_DEF   = 64'h7C00_001F_0000_0000;
  localparam int          PCNT_W         = 2;
  localparam int          RF_SYNC_STAGES = 2;

  // Bit counter must be able to hold the value pkt_w itself.
  function automatic int bcnt_width(input int pkt_w);
    return $clog2(pkt_w + 1);
  endfunction

endpackage

// File: rtl/rf_pulse_sync.sv
// Optional flop-chain synchronizer followed by a registered rising-edge detector.
// rise_o is a one-cycle pulse, one edge after the synchronized input goes high.
module rf_pulse_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic d_i,
  output logic rise_o
);

  logic sync_val;
  logic prev_q;
  logic rise_q;

  generate
    if (STAGES == 0) begin : g_direct
      // Caller guarantees d_i already lives in the clk_i domain.
      assign sync_val = d_i;
    end else begin : g_sync
      logic [STAGES-1:0] sync_q;
      always_ff @(posedge clk_i) begin
        if (srst_i) begin
          sync_q <= '0;
        end else begin
          sync_q <= (sync_q << 1) | STAGES'(d_i);
        end
      end
      assign sync_val = sync_q[STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= sync_val;
      rise_q <= sync_val & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/rf_pkt_capture.sv
// RF pulse-position packet capture: counts pulses per bit window, shifts bits in,
// and latches a packet once PKT_W bits carry the sync pattern.
module rf_pkt_capture
  import rf_pkt_pkg::*;
#(
  parameter int               PKT_W     = PKT_W_DEF,
  parameter logic [PKT_W-1:0] SYNC_MASK = SYNC_MASK_DEF,
  parameter logic [PKT_W-1:0] SYNC_PAT  = SYNC_PAT_DEF
) (
  input  logic             i_PCLK,
  input  logic             i_RST,
  input  logic             i_RX,
  input  logic             rfin,
  input  logic             sh_en,
  input  logic             i_PKT_ACK,
  output logic [PKT_W-1:0] o_PKT,
  output logic             pkt_rec,
  output logic             o_OVR,
  output logic             o_ERR
);

  localparam int                BCNT_W    = bcnt_width(PKT_W);
  localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(PKT_W);

  cap_state_t        state_q, state_d;
  logic [PKT_W-1:0]  sr_q, sr_d;
  logic [PKT_W-1:0]  pkt_q, pkt_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              ovr_q, ovr_d;
  logic              err_q, err_d;
  logic              shifted_q, shifted_d;
  logic              rx_q;
  logic              pulse_ev;
  logic              win_close;
  logic              match;

  rf_pulse_sync #(.STAGES(RF_SYNC_STAGES)) u_rf_sync (
    .clk_i  (i_PCLK),
    .srst_i (i_RST),
    .d_i    (rfin),
    .rise_o (pulse_ev)
  );

  // sh_en is already synchronous, so only its edge detector is used.
  rf_pulse_sync #(.STAGES(0)) u_sh_sync (
    .clk_i  (i_PCLK),
    .srst_i (i_RST),
    .d_i    (sh_en),
    .rise_o (win_close)
  );

  // Only look for sync on the cycle right after a shift, so a held sr cannot re-match.
  assign match = shifted_q && (bcnt_q == BCNT_FULL) && ((sr_q & SYNC_MASK) == SYNC_PAT);

  always_ff @(posedge i_PCLK) begin
    if (i_RST) begin
      state_q   <= HUNT;
      sr_q      <= '0;
      pkt_q     <= '0;
      pcnt_q    <= '0;
      bcnt_q    <= '0;
      ovr_q     <= 1'b0;
      err_q     <= 1'b0;
      shifted_q <= 1'b0;
      rx_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      pkt_q     <= pkt_d;
      pcnt_q    <= pcnt_d;
      bcnt_q    <= bcnt_d;
      ovr_q     <= ovr_d;
      err_q     <= err_d;
      shifted_q <= shifted_d;
      rx_q      <= i_RX;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    pkt_d     = pkt_q;
    pcnt_d    = pcnt_q;
    bcnt_d    = bcnt_q;
    ovr_d     = ovr_q;
    err_d     = err_q;
    shifted_d = 1'b0;

    if (!i_RX) begin
      state_d = HUNT;
      sr_d    = '0;
      pcnt_d  = '0;
      bcnt_d  = '0;
    end else begin
      if (!rx_q) begin
        ovr_d = 1'b0;
        err_d = 1'b0;
      end

      if (win_close) begin
        sr_d      = {sr_q[PKT_W-2:0], (pcnt_q != '0)};
        shifted_d = 1'b1;
        if (pcnt_q >= PCNT_W'(2)) begin
          err_d = 1'b1;
        end
        if (bcnt_q != BCNT_FULL) begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
        // A pulse landing on the closing edge belongs to the next window.
        pcnt_d = PCNT_W'(pulse_ev);
      end else if (pulse_ev && (pcnt_q != '1)) begin
        pcnt_d = pcnt_q + PCNT_W'(1);
      end

      if (state_q == HUNT) begin
        if (match) begin
          state_d = HOLD;
          pkt_d   = sr_q;
        end
      end else begin
        if (match) begin
          ovr_d = 1'b1;
        end
        if (i_PKT_ACK) begin
          state_d   = HUNT;
          sr_d      = '0;
          bcnt_d    = '0;
          shifted_d = 1'b0;
        end
      end
    end
  end

  assign o_PKT   = pkt_q;
  assign pkt_rec = (state_q == HOLD);
  assign o_OVR   = ovr_q;
  assign o_ERR   = err_q;

endmodule

// File: doc/rf_pkt_capture.md
RF_PKT_CAPTURE -- requirements
Module: rf_pkt_capture

Interface
REQ-001 Parameter PKT_W, default 64: packet length in bits.
REQ-002 Parameter SYNC_MASK, default 64'h7C00_001F_0000_0000: bit positions checked for sync (bits 62..58 and 36..32).
REQ-003 Parameter SYNC_PAT, default 64'h7C00_001F_0000_0000: required values at the masked positions.
REQ-004 i_PCLK  in  1  single system clock; all state changes on its rising edge.
REQ-005 i_RST  in  1  reset, synchronous and active-high.
REQ-006 i_RX  in  1  receive enable; 0 holds the capture path idle.
REQ-007 rfin  in  1  asynchronous RF pulse input; a pulse is at least one i_PCLK period wide.
REQ-008 sh_en  in  1  bit-period strobe, synchronous to i_PCLK; its rising edge closes one bit window.
REQ-009 i_PKT_ACK  in  1  one-cycle acknowledge from the APB RX read path.
REQ-010 o_PKT  out  PKT_W  latched packet; first received bit in o_PKT[PKT_W-1].
REQ-011 pkt_rec  out  1  packet available, held until acknowledged.
REQ-012 o_OVR  out  1  sticky overrun flag.
REQ-013 o_ERR  out  1  sticky flag: more than one pulse seen in one bit window.

Function
REQ-014 rfin shall pass through a 2-flop synchronizer; a rising edge of the synchronized signal is one pulse event.
REQ-015 A 2-bit saturating pulse counter shall count pulse events within the current bit window.
REQ-016 On each sh_en rising edge with i_RX=1: shift register shifts left; new LSB = 1 if counter>=1, else 0; counter clears.
REQ-017 A pulse event in the same cycle as the sh_en rising edge shall count toward the next window (counter loads 1).
REQ-018 Counter value 2 or 3 at window close shall set o_ERR; shifted bit is still 1.
REQ-019 A saturating bit counter (0..PKT_W) shall count shifts since entering HUNT with cleared state.
REQ-020 Match = bit counter==PKT_W and (sr & SYNC_MASK)==SYNC_PAT, evaluated on the registered sr one cycle after the shift.
REQ-021 States: HUNT, HOLD.
REQ-022 HUNT + match -> HOLD: o_PKT <= sr, pkt_rec <= 1, in the same edge; latency sh_en edge to pkt_rec = 3 cycles (1 edge detect, 1 shift, 1 compare/latch).
REQ-023 HOLD: shifting continues; o_PKT frozen; a further match sets o_OVR; o_PKT is not overwritten.
REQ-024 HOLD + i_PKT_ACK -> HUNT: pkt_rec <= 0; sr and bit counter clear so the next packet needs PKT_W fresh bits.
REQ-025 Ack and match in the same cycle: the ack wins; state HUNT, o_OVR set; no new packet is latched.
REQ-026 i_PKT_ACK in HUNT shall be ignored.
REQ-027 i_RX=0: sr, pulse counter and bit counter clear; state HUNT; pkt_rec clears. o_PKT, o_OVR and o_ERR hold.
REQ-028 o_OVR and o_ERR shall clear only on reset, or on i_RX rising 0->1.

Reset
REQ-029 i_RST=1 at a clock edge: state HUNT; sr, o_PKT, both counters and synchronizer flops = 0; pkt_rec, o_OVR, o_ERR = 0.
REQ-030 Reset mid-window or mid-HOLD shall discard all partial and held data with no further output activity.

Structure
REQ-031 Shared package rf_pkt_pkg: state enum (HUNT, HOLD), PKT_W default, SYNC_MASK/SYNC_PAT defaults, counter widths.
REQ-032 One sub-module rf_pulse_sync: 2-flop synchronizer plus rising-edge detector. Instantiate it once for rfin and once for sh_en edge detection.
REQ-033 Output drives the existing packet-register/APB RX path unchanged: o_PKT feeds pkt_reg, pkt_rec feeds the status bit.
REQ-034 Target implementation size: 120-300 lines RTL.

Verification
REQ-035 Reset, then 64 windows with bit sequence 64'h7C5A_A01F_3C00_0001 (one 100 ns pulse at 30 % of each 1-bit window) -> pkt_rec rises 3 cycles after the 64th sh_en edge; o_PKT=64'h7C5A_A01F_3C00_0001.
REQ-036 Same stream with bit 60 = 0 -> no pkt_rec after 64 or more windows; o_PKT stays 0.
REQ-037 Window with two pulses 200 ns apart -> shifted bit=1, o_ERR=1; o_ERR persists until i_RX toggles 0->1.
REQ-038 Valid packet, no ack, second valid packet 64 windows later -> o_OVR=1; o_PKT keeps the first value. Then ack -> pkt_rec=0.
REQ-039 Pulse synchronized exactly on the sh_en edge cycle -> counted in the following window (bit 0 for the closing window, bit 1 next).
REQ-040 i_RST asserted for 1 cycle during HOLD, or i_RX dropped after 40 bits -> pkt_rec=0, sr=0; a full 64-bit valid frame is needed before the next pkt_rec.
